// File: rtl/tinv_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : tinv_bus_arbiter_if
//  Description : Shared tri-state bus bundle between the channel requesters
//                (master) and the bus arbiter that drives the tinv columns
//                (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface tinv_bus_arbiter_if #(
   parameter int N = 4,
   parameter int W = 8
);
   logic [N-1:0]   req;
   logic [N*W-1:0] a;
   logic [N-1:0]   gnt;
   logic [N-1:0]   en;
   logic [N-1:0]   en_bar;
   logic [W-1:0]   y;
   logic           oe;
   logic           busy;

   modport master (
      output req, a,
      input  gnt, en, en_bar, y, oe, busy
   );

   modport slave (
      input  req, a,
      output gnt, en, en_bar, y, oe, busy
   );
endinterface
`default_nettype wire

// File: rtl/tinv_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tinv_bus_arbiter
//  Description : Round-robin owner selection for N tri-state inverter driver
//                channels on one shared W-bit bus. Generates registered,
//                complementary EN/EN_BAR pairs with break-before-make dead
//                time, an optional per-owner hold limit and a bus keeper.
//  Revision    : 1.0 - initial release
// ============================================================================
module tinv_bus_arbiter #(
   parameter int N        = 4,
   parameter int W        = 8,
   parameter int DEAD_CYC = 2,
   parameter int MAX_HOLD = 8,
   parameter int INV      = 1
) (
   input  logic              clk,
   input  logic              rn,
   tinv_bus_arbiter_if.slave bus
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;
   localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
   localparam logic [3:0]    DEAD_C = 4'(DEAD_CYC);
   localparam logic [HW-1:0] HOLD_C = HW'(MAX_HOLD);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      DEAD  = 2'd2
   } state_t;

   state_t        state;
   logic [N-1:0]  gnt;
   logic [PW-1:0] ptr;
   logic [PW-1:0] owner;
   logic [HW-1:0] hold;
   logic [3:0]    gap;
   logic [W-1:0]  keep;

   logic [N-1:0]  win_oh;
   logic [PW-1:0] win_idx;
   logic          any_req;
   logic          others_req;
   logic          gap_ok;
   logic [W-1:0]  owner_a;
   logic [W-1:0]  drv_out;
   logic [HW-1:0] hold_inc;
   logic          release_now;
   logic [PW-1:0] ptr_next;

   assign any_req    = |bus.req;
   assign others_req = |(bus.req & ~gnt);
   assign gap_ok     = (gap >= DEAD_C);

   // Round-robin search: first set REQ bit at or above ptr, wrapping to 0.
   always_comb begin
      int   idx;
      logic found;
      win_oh  = '0;
      win_idx = '0;
      found   = 1'b0;
      idx     = 0;
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N) idx = idx - N;
         if (!found && bus.req[idx]) begin
            found       = 1'b1;
            win_oh[idx] = 1'b1;
            win_idx     = PW'(idx);
         end
      end
   end

   // Owner data select: the grant is one-hot, so an AND-OR mux is enough.
   always_comb begin
      owner_a = '0;
      for (int i = 0; i < N; i++) begin
         owner_a = owner_a | (bus.a[i*W +: W] & {W{gnt[i]}});
      end
      drv_out = (INV != 0) ? ~owner_a : owner_a;
   end

   // Hold counter saturates at the limit so a lone owner keeps the bus, and
   // a release happens on the first edge another channel shows up.
   always_comb begin
      hold_inc    = (hold == HOLD_C) ? hold : hold + 1'b1;
      release_now = !bus.req[owner] ||
                    ((MAX_HOLD != 0) && (hold_inc == HOLD_C) && others_req);
      ptr_next    = (owner == PW'(N - 1)) ? '0 : owner + 1'b1;
   end

   // Ownership FSM: grant, drive, dead-time, plus the keeper register.
   always_ff @(posedge clk or negedge rn) begin
      if (!rn) begin
         state <= IDLE;
         gnt   <= '0;
         ptr   <= '0;
         owner <= '0;
         hold  <= '0;
         gap   <= DEAD_C;
         keep  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req && gap_ok) begin
                  gnt   <= win_oh;
                  owner <= win_idx;
                  hold  <= '0;
                  state <= DRIVE;
               end else begin
                  if (!gap_ok) gap <= gap + 4'd1;
                  if (any_req) state <= DEAD;
               end
            end
            DRIVE: begin
               keep <= drv_out;
               hold <= hold_inc;
               if (release_now) begin
                  gnt   <= '0;
                  ptr   <= ptr_next;
                  hold  <= '0;
                  // The low cycle that starts at this edge is the first one.
                  gap   <= 4'd1;
                  state <= DEAD;
               end
            end
            DEAD: begin
               if (gap_ok) begin
                  if (any_req) begin
                     gnt   <= win_oh;
                     owner <= win_idx;
                     hold  <= '0;
                     state <= DRIVE;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  gap <= gap + 4'd1;
               end
            end
            default: begin
               state <= IDLE;
               gnt   <= '0;
            end
         endcase
      end
   end

   assign bus.gnt    = gnt;
   assign bus.en     = gnt;
   assign bus.en_bar = ~gnt;
   assign bus.oe     = |gnt;
   assign bus.busy   = (state != IDLE);
   assign bus.y      = bus.oe ? drv_out : keep;

endmodule
`default_nettype wire

// File: tb/tb_tinv_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tinv_bus_arbiter
//  Description : Self-checking bench for tinv_bus_arbiter. A 4x8 inverting
//                instance runs a vector table through a scoreboard queue; a
//                2x16 non-inverting instance and async reset are exercised
//                with hand-written sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tinv_bus_arbiter;

   logic clk = 1'b0;
   logic rn;

   always #5 clk = ~clk;

   tinv_bus_arbiter_if #(.N(4), .W(8))  bus  ();
   tinv_bus_arbiter_if #(.N(2), .W(16)) bus2 ();

   tinv_bus_arbiter #(.N(4), .W(8), .DEAD_CYC(2), .MAX_HOLD(8), .INV(1)) dut (
      .clk (clk),
      .rn  (rn),
      .bus (bus)
   );

   tinv_bus_arbiter #(.N(2), .W(16), .DEAD_CYC(1), .MAX_HOLD(0), .INV(0)) dut2 (
      .clk (clk),
      .rn  (rn),
      .bus (bus2)
   );

   typedef struct {
      bit         rst;   // pulse reset before applying this row
      logic [3:0] req;
      logic [3:0] en;    // expected EN (== GNT) after the edge
      logic [7:0] y;
      logic       busy;
   } vec_t;

   vec_t tbl[$];
   vec_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input bit r, input logic [3:0] q, input logic [3:0] e,
                      input logic [7:0] y, input logic b);
      vec_t v;
      v.rst = r; v.req = q; v.en = e; v.y = y; v.busy = b;
      tbl.push_back(v);
   endtask

   task automatic chk_reset4(input string tag);
      chk({tag, "_en"},     32'(bus.en),     32'h0);
      chk({tag, "_en_bar"}, 32'(bus.en_bar), 32'hF);
      chk({tag, "_gnt"},    32'(bus.gnt),    32'h0);
      chk({tag, "_oe"},     32'(bus.oe),     32'h0);
      chk({tag, "_busy"},   32'(bus.busy),   32'h0);
      chk({tag, "_y"},      32'(bus.y),      32'h0);
   endtask

   task automatic step2(input string tag, input logic [1:0] q, input logic [1:0] e,
                        input logic [15:0] y, input logic b);
      logic [1:0] eb;
      @(negedge clk);
      bus2.req = q;
      @(posedge clk);
      #1;
      eb = ~e;
      chk({tag, "_en"},     32'(bus2.en),     32'(e));
      chk({tag, "_en_bar"}, 32'(bus2.en_bar), 32'(eb));
      chk({tag, "_oe"},     32'(bus2.oe),     32'(|e));
      chk({tag, "_y"},      32'(bus2.y),      32'(y));
      chk({tag, "_busy"},   32'(bus2.busy),   32'(b));
   endtask

   initial begin
      vec_t       exp;
      logic [3:0] eb;

      bus.req  = '0;
      bus.a    = {8'hF0, 8'h5A, 8'h11, 8'h3C};   // ~A: 0F A5 EE C3
      bus2.req = '0;
      bus2.a   = {16'hBEEF, 16'h1234};

      // Asynchronous reset before any clock edge.
      rn = 1'b1;
      #1 rn = 1'b0;
      #2;
      chk_reset4("por");
      chk("por_y2", 32'(bus2.y), 32'h0);
      @(negedge clk);
      rn = 1'b1;

      // Latency and break-before-make (dead time 2, keeper holds C3).
      add(0, 4'b0000, 4'b0000, 8'h00, 0);
      add(0, 4'b0000, 4'b0000, 8'h00, 0);
      add(0, 4'b0001, 4'b0001, 8'hC3, 1);
      add(0, 4'b0101, 4'b0001, 8'hC3, 1);
      add(0, 4'b0100, 4'b0000, 8'hC3, 1);
      add(0, 4'b0100, 4'b0000, 8'hC3, 1);
      add(0, 4'b0100, 4'b0100, 8'hA5, 1);
      add(0, 4'b0000, 4'b0000, 8'hA5, 1);
      add(0, 4'b0000, 4'b0000, 8'hA5, 1);
      add(0, 4'b0000, 4'b0000, 8'hA5, 0);
      // Round robin after reset: 0,1,2,3,0, each owner 3 cycles.
      add(1, 4'b1111, 4'b0001, 8'hC3, 1);
      add(0, 4'b1111, 4'b0001, 8'hC3, 1);
      add(0, 4'b1111, 4'b0001, 8'hC3, 1);
      add(0, 4'b1110, 4'b0000, 8'hC3, 1);
      add(0, 4'b1111, 4'b0000, 8'hC3, 1);   // owner 0 re-raises during DEAD
      add(0, 4'b1111, 4'b0010, 8'hEE, 1);
      add(0, 4'b1111, 4'b0010, 8'hEE, 1);
      add(0, 4'b1111, 4'b0010, 8'hEE, 1);
      add(0, 4'b1101, 4'b0000, 8'hEE, 1);
      add(0, 4'b1111, 4'b0000, 8'hEE, 1);
      add(0, 4'b1111, 4'b0100, 8'hA5, 1);
      add(0, 4'b1111, 4'b0100, 8'hA5, 1);
      add(0, 4'b1111, 4'b0100, 8'hA5, 1);
      add(0, 4'b1011, 4'b0000, 8'hA5, 1);
      add(0, 4'b1111, 4'b0000, 8'hA5, 1);
      add(0, 4'b1111, 4'b1000, 8'h0F, 1);
      add(0, 4'b1111, 4'b1000, 8'h0F, 1);
      add(0, 4'b1111, 4'b1000, 8'h0F, 1);
      add(0, 4'b0111, 4'b0000, 8'h0F, 1);
      add(0, 4'b1111, 4'b0000, 8'h0F, 1);
      add(0, 4'b1111, 4'b0001, 8'hC3, 1);
      add(0, 4'b0000, 4'b0000, 8'hC3, 1);
      add(0, 4'b0000, 4'b0000, 8'hC3, 1);
      add(0, 4'b0000, 4'b0000, 8'hC3, 0);
      // Hold limit: channel 1 forced off after 8 DRIVE cycles by channel 3.
      add(0, 4'b0010, 4'b0010, 8'hEE, 1);
      for (int k = 0; k < 7; k++) add(0, 4'b1010, 4'b0010, 8'hEE, 1);
      add(0, 4'b1010, 4'b0000, 8'hEE, 1);
      add(0, 4'b1010, 4'b0000, 8'hEE, 1);
      add(0, 4'b1010, 4'b1000, 8'h0F, 1);
      // Lone requester keeps the bus; hold saturates.
      for (int k = 0; k < 20; k++) add(0, 4'b1000, 4'b1000, 8'h0F, 1);
      // Saturated hold releases on the first edge another channel waits.
      add(0, 4'b1010, 4'b0000, 8'h0F, 1);
      add(0, 4'b1010, 4'b0000, 8'h0F, 1);
      add(0, 4'b1010, 4'b0010, 8'hEE, 1);
      add(0, 4'b0000, 4'b0000, 8'hEE, 1);
      add(0, 4'b0000, 4'b0000, 8'hEE, 1);
      add(0, 4'b0000, 4'b0000, 8'hEE, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         @(negedge clk);
         if (tbl[i].rst) begin
            rn = 1'b0;
            #1;
            chk_reset4($sformatf("row%0d_rst", i));
            @(negedge clk);
            rn = 1'b1;
         end
         bus.req = tbl[i].req;
         sb.push_back(tbl[i]);
         @(posedge clk);
         #1;
         exp = sb.pop_front();
         eb  = ~exp.en;
         chk($sformatf("row%0d_en", i),     32'(bus.en),     32'(exp.en));
         chk($sformatf("row%0d_en_bar", i), 32'(bus.en_bar), 32'(eb));
         chk($sformatf("row%0d_gnt", i),    32'(bus.gnt),    32'(exp.en));
         chk($sformatf("row%0d_oe", i),     32'(bus.oe),     32'(|exp.en));
         chk($sformatf("row%0d_y", i),      32'(bus.y),      32'(exp.y));
         chk($sformatf("row%0d_busy", i),   32'(bus.busy),   32'(exp.busy));
      end

      // Async reset between edges while channel 2 owns the bus.
      @(negedge clk);
      bus.req = 4'b0100;
      @(posedge clk);
      #1;
      chk("arst_pre_en", 32'(bus.en), 32'h4);
      chk("arst_pre_y",  32'(bus.y),  32'hA5);
      #2;
      rn = 1'b0;
      #1;
      chk_reset4("arst");
      @(negedge clk);
      bus.req = '0;
      @(negedge clk);
      rn = 1'b1;

      // Non-inverting 2x16 instance, one dead cycle, no hold limit.
      step2("d2_g1",   2'b10, 2'b10, 16'hBEEF, 1);
      step2("d2_rel",  2'b01, 2'b00, 16'hBEEF, 1);
      step2("d2_g0",   2'b01, 2'b01, 16'h1234, 1);
      for (int k = 0; k < 12; k++)
         step2($sformatf("d2_keep%0d", k), 2'b11, 2'b01, 16'h1234, 1);
      step2("d2_rel0", 2'b10, 2'b00, 16'h1234, 1);
      step2("d2_g1b",  2'b10, 2'b10, 16'hBEEF, 1);
      step2("d2_rel1", 2'b00, 2'b00, 16'hBEEF, 1);
      step2("d2_idle", 2'b00, 2'b00, 16'hBEEF, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
